// File: rtl/even_odd_pkg.sv
// Shared types and defaults for the even/odd tally block.
// Optional even-value sum is enabled by defining EVEN_SUM_EN.
package even_odd_pkg;

    typedef enum logic [0:0] {
        ACCUM,
        REPORT
    } state_e;

    localparam int unsigned DefWindow = 8;
    localparam int unsigned DefCntW   = 4;

endpackage

// File: rtl/even_run_tracker.sv
// Tracks the current run of consecutive even samples and the longest run seen in the window.
module even_run_tracker
#(
    parameter int unsigned CNT_W = even_odd_pkg::DefCntW
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             accept,
    input  logic             is_even,
    input  logic             clear,
    output logic [CNT_W-1:0] max_even_run
);

    logic [CNT_W-1:0] cur_run_q;
    logic [CNT_W-1:0] max_run_q;
    logic [CNT_W-1:0] run_inc;

    assign run_inc = cur_run_q + CNT_W'(1);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            cur_run_q <= '0;
            max_run_q <= '0;
        end else if (accept) begin
            if (is_even) begin
                cur_run_q <= run_inc;
                if (run_inc > max_run_q) begin
                    max_run_q <= run_inc;
                end
            end else begin
                cur_run_q <= '0;
            end
        end
    end

    assign max_even_run = max_run_q;

endmodule

// File: rtl/even_odd_tally.sv
// Windowed even/odd sample tally with a valid/ready report handshake.
// Define EVEN_SUM_EN to add the even_sum output and its accumulator.
module even_odd_tally
#(
    parameter int unsigned WINDOW = even_odd_pkg::DefWindow,
    parameter int unsigned CNT_W  = even_odd_pkg::DefCntW
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [7:0]         number,
    input  logic               is_even,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [CNT_W-1:0]   even_count,
    output logic [CNT_W-1:0]   odd_count,
`ifdef EVEN_SUM_EN
    output logic [8+CNT_W-1:0] even_sum,
`endif
    output logic [CNT_W-1:0]   max_even_run
);
    import even_odd_pkg::*;

    localparam int unsigned SmpW = $clog2(WINDOW + 1);

    state_e            state_q;
    logic              in_ready_q;
    logic              out_valid_q;
    logic [SmpW-1:0]   smp_cnt_q;
    logic [CNT_W-1:0]  even_q;
    logic [CNT_W-1:0]  odd_q;
    logic              accept;
    logic              report_done;

    assign accept      = in_valid & in_ready_q;
    assign report_done = out_valid_q & out_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ACCUM;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            smp_cnt_q   <= '0;
            even_q      <= '0;
            odd_q       <= '0;
        end else begin
            case (state_q)
                ACCUM: begin
                    if (accept) begin
                        if (is_even) begin
                            even_q <= even_q + CNT_W'(1);
                        end else begin
                            odd_q <= odd_q + CNT_W'(1);
                        end
                        if (smp_cnt_q == SmpW'(WINDOW - 1)) begin
                            state_q     <= REPORT;
                            in_ready_q  <= 1'b0;
                            out_valid_q <= 1'b1;
                            smp_cnt_q   <= '0;
                        end else begin
                            smp_cnt_q <= smp_cnt_q + SmpW'(1);
                        end
                    end
                end
                REPORT: begin
                    // Report values hold until the downstream takes them.
                    if (out_ready) begin
                        state_q     <= ACCUM;
                        in_ready_q  <= 1'b1;
                        out_valid_q <= 1'b0;
                        smp_cnt_q   <= '0;
                        even_q      <= '0;
                        odd_q       <= '0;
                    end
                end
                default: begin
                    state_q <= ACCUM;
                end
            endcase
        end
    end

`ifdef EVEN_SUM_EN
    logic [8+CNT_W-1:0] sum_q;

    always_ff @(posedge clk) begin
        if (reset || report_done) begin
            sum_q <= '0;
        end else if (accept && is_even) begin
            sum_q <= sum_q + {{CNT_W{1'b0}}, number};
        end
    end

    assign even_sum = sum_q;
`else
    // Sample value only feeds the optional sum; keep it visibly consumed.
    logic unused_number;
    assign unused_number = ^number;
`endif

    even_run_tracker #(
        .CNT_W (CNT_W)
    ) u_run_tracker (
        .clk          (clk),
        .reset        (reset),
        .accept       (accept),
        .is_even      (is_even),
        .clear        (report_done),
        .max_even_run (max_even_run)
    );

    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign even_count = even_q;
    assign odd_count  = odd_q;

endmodule

// File: tb/tb_even_odd_tally.sv
// Directed bench for even_odd_tally (WINDOW=8, CNT_W=4); works with or without EVEN_SUM_EN.
module tb_even_odd_tally;

    localparam int unsigned WINDOW = 8;
    localparam int unsigned CNT_W  = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              in_valid;
    logic              in_ready;
    logic [7:0]        number;
    logic              is_even;
    logic              out_valid;
    logic              out_ready;
    logic [CNT_W-1:0]  even_count;
    logic [CNT_W-1:0]  odd_count;
    logic [CNT_W-1:0]  max_even_run;
`ifdef EVEN_SUM_EN
    logic [8+CNT_W-1:0] even_sum;
`endif

    int n_pass  = 0;
    int n_total = 0;

    even_odd_tally #(
        .WINDOW (WINDOW),
        .CNT_W  (CNT_W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .number       (number),
        .is_even      (is_even),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .even_count   (even_count),
        .odd_count    (odd_count),
`ifdef EVEN_SUM_EN
        .even_sum     (even_sum),
`endif
        .max_even_run (max_even_run)
    );

    always #5 clk = ~clk;

    // Advance one clock; outputs are then sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic check_report(input string tag, input int ev, input int od, input int mx,
                                input int sm);
        check({tag, " even_count"}, 32'(even_count), ev);
        check({tag, " odd_count"}, 32'(odd_count), od);
        check({tag, " max_even_run"}, 32'(max_even_run), mx);
`ifdef EVEN_SUM_EN
        check({tag, " even_sum"}, 32'(even_sum), sm);
`else
        if (sm < 0) $display("unused sum %0d", sm);
`endif
    endtask

    task automatic feed(input logic [7:0] val);
        in_valid = 1'b1;
        number   = val;
        is_even  = ~val[0];
        step();
    endtask

    task automatic handshake();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    initial begin
        logic [7:0] run_vec [8];
        run_vec = '{8'd2, 8'd4, 8'd6, 8'd1, 8'd8, 8'd10, 8'd3, 8'd5};

        reset     = 1'b1;
        in_valid  = 1'b0;
        number    = 8'd0;
        is_even   = 1'b0;
        out_ready = 1'b0;

        // Reset held two cycles
        step();
        step();
        check("reset out_valid", 32'(out_valid), 0);
        check("reset in_ready", 32'(in_ready), 1);
        check_report("reset", 0, 0, 0, 0);
        reset = 1'b0;

        // Alternating 6,11 x4
        for (int i = 0; i < 8; i++) begin
            feed((i % 2 == 0) ? 8'd6 : 8'd11);
            if (i == 6) check("alt out_valid before 8th", 32'(out_valid), 0);
        end
        check("alt out_valid", 32'(out_valid), 1);
        check("alt in_ready", 32'(in_ready), 0);
        check_report("alt", 4, 4, 1, 24);
        handshake();
        check("alt post out_valid", 32'(out_valid), 0);
        check("alt post in_ready", 32'(in_ready), 1);
        check_report("alt post", 0, 0, 0, 0);

        // Run scenario
        for (int i = 0; i < 8; i++) feed(run_vec[i]);
        check("run out_valid", 32'(out_valid), 1);
        check_report("run", 5, 3, 3, 30);

        // Backpressure with in_valid held high during REPORT
        in_valid = 1'b1;
        number   = 8'd7;
        is_even  = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            check("bp in_ready", 32'(in_ready), 0);
            check("bp out_valid", 32'(out_valid), 1);
        end
        check_report("bp hold", 5, 3, 3, 30);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("bp post in_ready", 32'(in_ready), 1);
        check_report("bp post", 0, 0, 0, 0);
        feed(8'd7);
        check_report("fresh window", 0, 1, 0, 0);

        // Mid-window reset after five accepts; in_valid stays high through reset
        for (int i = 0; i < 4; i++) feed(8'd2);
        check_report("pre reset", 4, 1, 4, 8);
        reset = 1'b1;
        feed(8'd4);
        reset = 1'b0;
        check("midreset in_ready", 32'(in_ready), 1);
        check_report("midreset", 0, 0, 0, 0);
        for (int i = 0; i < 8; i++) begin
            feed(8'd11);
            if (i == 6) check("odd out_valid before 8th", 32'(out_valid), 0);
        end
        check("odd out_valid", 32'(out_valid), 1);
        check_report("odd", 0, 8, 0, 0);
        handshake();

        // Gap scenario: in_valid toggles, eight samples of 2
        number  = 8'd2;
        is_even = 1'b1;
        for (int i = 0; i < 16; i++) begin
            in_valid = (i % 2 == 0);
            step();
            if (i == 13) check("gap out_valid before 8th", 32'(out_valid), 0);
        end
        check("gap out_valid", 32'(out_valid), 1);
        check_report("gap", 8, 0, 8, 16);
        handshake();
        check("gap post out_valid", 32'(out_valid), 0);
        check_report("gap post", 0, 0, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
